// File: rtl/alu_multicycle_if.sv
// Bus between the control FSM and alu_multicycle: operand sources, op select and the
// Start/Busy/Done handshake with the registered result and flags.
interface alu_multicycle_if #(
  parameter int pBuswidth = 32
) ();
  // Handshake: Start is a one-cycle request honoured only while the FSM is idle
  // (Busy low); Busy covers the cycles of an iterative operation; Done pulses for one
  // cycle when ALU_result and the flags change. A Start in the Done cycle is accepted.
  logic                 Start;
  logic [pBuswidth-1:0] PC;
  logic [pBuswidth-1:0] ReadData1;
  logic [pBuswidth-1:0] ReadData2;
  logic [15:0]          Instruction;
  logic                 ALUSelA;
  logic [1:0]           ALUSelB;
  logic [1:0]           ALUOp;
  logic                 Busy;
  logic                 Done;
  logic [pBuswidth-1:0] ALU_result;
  logic                 Zero;
  logic                 Negative;
  logic                 Carry;
  logic                 Overflow;
  logic                 IllegalOp;
  logic [1:0]           fsm_state;

  modport master (
    output Start, PC, ReadData1, ReadData2, Instruction, ALUSelA, ALUSelB, ALUOp,
    input  Busy, Done, ALU_result, Zero, Negative, Carry, Overflow, IllegalOp, fsm_state
  );

  modport slave (
    input  Start, PC, ReadData1, ReadData2, Instruction, ALUSelA, ALUSelB, ALUOp,
    output Busy, Done, ALU_result, Zero, Negative, Carry, Overflow, IllegalOp, fsm_state
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle add/sub/logic, bit-serial shifts by shamt and a
// shift-add multiplier, with NZCV flags, illegal-op detection and Start/Busy/Done.
module alu_multicycle #(
  parameter int pBuswidth   = 32,
  parameter int pShamtWidth = 5
) (
  input logic              Clk,
  input logic              Reset,
  alu_multicycle_if.slave  bus
);
  localparam int W  = pBuswidth;
  localparam int CW = (pShamtWidth > $clog2(W + 1)) ? pShamtWidth : $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
  } op_t;

  state_t               state, state_next;
  op_t                  op, op_q;
  logic [W-1:0]         op_a, op_b;
  logic [pShamtWidth-1:0] shamt;
  logic [W:0]           sum_add, sum_sub;
  logic [W-1:0]         sc_res;
  logic                 sc_c, sc_v, sc_ill;
  logic [CW-1:0]        cnt;
  logic [W-1:0]         sh_reg, mul_b, acc, shifted, acc_next;
  logic                 fin, fin_c, fin_v, fin_ill;
  logic [W-1:0]         fin_res;
  logic                 done_q, zero_q, neg_q, carry_q, ovf_q, ill_q;
  logic [W-1:0]         res_q;

  always_comb begin
    op_a  = bus.ALUSelA ? bus.ReadData1 : bus.PC;
    shamt = bus.Instruction[6+pShamtWidth-1:6];
    case (bus.ALUSelB)
      2'b00:   op_b = bus.ReadData2;
      2'b01:   op_b = W'(1);
      default: op_b = {{(W-16){bus.Instruction[15]}}, bus.Instruction};
    endcase
    case (bus.ALUOp)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (bus.Instruction[5:0])
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100110: op = OP_XOR;
          6'b000000: op = OP_SLL;
          6'b000010: op = OP_SRL;
          6'b000011: op = OP_SRA;
          6'b011000: op = OP_MUL;
          default:   op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  // Subtraction is A + ~B + 1 so Carry reads as NOT borrow.
  always_comb begin
    sum_add = {1'b0, op_a} + {1'b0, op_b};
    sum_sub = {1'b0, op_a} + {1'b0, ~op_b} + {{W{1'b0}}, 1'b1};
    sc_res  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_ill  = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = sum_add[W-1:0];
        sc_c   = sum_add[W];
        sc_v   = (op_a[W-1] == op_b[W-1]) && (sum_add[W-1] != op_a[W-1]);
      end
      OP_SUB: begin
        sc_res = sum_sub[W-1:0];
        sc_c   = sum_sub[W];
        sc_v   = (op_a[W-1] != op_b[W-1]) && (sum_sub[W-1] != op_a[W-1]);
      end
      OP_AND:                 sc_res = op_a & op_b;
      OP_OR:                  sc_res = op_a | op_b;
      OP_XOR:                 sc_res = op_a ^ op_b;
      OP_SLL, OP_SRL, OP_SRA: sc_res = op_b;
      OP_MUL:                 sc_res = '0;
      default:                sc_ill = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fin        = 1'b0;
    fin_res    = '0;
    fin_c      = 1'b0;
    fin_v      = 1'b0;
    fin_ill    = 1'b0;
    case (op_q)
      OP_SLL:  shifted = sh_reg << 1;
      OP_SRA:  shifted = {sh_reg[W-1], sh_reg[W-1:1]};
      default: shifted = sh_reg >> 1;
    endcase
    acc_next = acc + (mul_b[0] ? sh_reg : '0);
    case (state)
      S_IDLE: begin
        if (bus.Start) begin
          if (op == OP_MUL) begin
            state_next = S_MUL;
          end else if ((op == OP_SLL || op == OP_SRL || op == OP_SRA) && shamt != '0) begin
            state_next = S_SHIFT;
          end else begin
            fin     = 1'b1;
            fin_res = sc_res;
            fin_c   = sc_c;
            fin_v   = sc_v;
            fin_ill = sc_ill;
          end
        end
      end
      S_SHIFT: begin
        if (cnt == CW'(1)) begin
          fin        = 1'b1;
          fin_res    = shifted;
          state_next = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt == CW'(1)) begin
          fin        = 1'b1;
          fin_res    = acc_next;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // In MUL, sh_reg holds the multiplicand moving left and mul_b the multiplier moving right.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt     <= '0;
      sh_reg  <= '0;
      mul_b   <= '0;
      acc     <= '0;
      op_q    <= OP_ADD;
      done_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        res_q   <= fin_res;
        zero_q  <= (fin_res == '0);
        neg_q   <= fin_res[W-1];
        carry_q <= fin_c;
        ovf_q   <= fin_v;
        ill_q   <= fin_ill;
      end
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            op_q   <= op;
            sh_reg <= (op == OP_MUL) ? op_a : op_b;
            mul_b  <= op_b;
            acc    <= '0;
            cnt    <= (op == OP_MUL) ? CW'(W) : CW'(shamt);
          end
        end
        S_SHIFT: begin
          sh_reg <= shifted;
          cnt    <= cnt - CW'(1);
        end
        S_MUL: begin
          acc    <= acc_next;
          sh_reg <= sh_reg << 1;
          mul_b  <= mul_b >> 1;
          cnt    <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy       = (state != S_IDLE);
  assign bus.Done       = done_q;
  assign bus.ALU_result = res_q;
  assign bus.Zero       = zero_q;
  assign bus.Negative   = neg_q;
  assign bus.Carry      = carry_q;
  assign bus.Overflow   = ovf_q;
  assign bus.IllegalOp  = ill_q;
  assign bus.fsm_state  = state;
endmodule
